// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: hh:mm:ss time-keeping and time-setting controller.
// RUN mode counts 1 Hz ticks; SET mode moves a field cursor (left/right) and
// adjusts the selected field (up/down) with per-field wrap and no carry.
// Optional feature macro: CLKSET_AUTOEXIT_EN -- when defined, SET mode is left
// automatically after TIMEOUT_SEC ticks with no arrow/up/down activity.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode,
  input  logic       i_tick,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_set,
  output logic [1:0] o_cursor
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_e;

  localparam logic [1:0] CUR_HOUR = 2'd0;
  localparam logic [1:0] CUR_MIN  = 2'd1;
  localparam logic [1:0] CUR_SEC  = 2'd2;

  // The idle counter is 6 bits wide, so the timeout must fit in 1..63.
  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63) begin : g_bad_timeout
    $error("clock_set_ctrl: TIMEOUT_SEC must be in 1..63");
  end

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [1:0] cursor_q, cursor_d;

`ifdef CLKSET_AUTOEXIT_EN
  logic [5:0] idle_q, idle_d;
`endif

  logic arrow, updn, adjust_any;
  assign arrow      = i_left | i_right;
  assign updn       = i_up | i_down;
  assign adjust_any = arrow | updn;

  // Next-state: mode FSM, time counting in RUN, cursor/field editing in SET.
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    cursor_d = cursor_q;
`ifdef CLKSET_AUTOEXIT_EN
    idle_d   = idle_q;
`endif
    case (state_q)
      RUN: begin
        // Tick is applied even when mode is pressed the same cycle.
        if (i_tick) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (i_mode) begin
          state_d  = SET;
          cursor_d = CUR_HOUR;
`ifdef CLKSET_AUTOEXIT_EN
          idle_d   = 6'd0;
`endif
        end
      end
      SET: begin
        if (i_mode) begin
          state_d  = RUN;
          cursor_d = CUR_HOUR;
`ifdef CLKSET_AUTOEXIT_EN
          idle_d   = 6'd0;
`endif
        end else begin
`ifdef CLKSET_AUTOEXIT_EN
          // Any edit button restarts the idle window, even with a tick present.
          if (adjust_any) begin
            idle_d = 6'd0;
          end else if (i_tick) begin
            if (idle_q + 6'd1 == 6'(TIMEOUT_SEC)) begin
              state_d  = RUN;
              cursor_d = CUR_HOUR;
              idle_d   = 6'd0;
            end else begin
              idle_d = idle_q + 6'd1;
            end
          end
`endif
          if (arrow) begin
            // Both arrows cancel; up/down are dropped whenever an arrow is present.
            if (i_left && !i_right) begin
              cursor_d = (cursor_q == CUR_HOUR) ? CUR_SEC : cursor_q - 2'd1;
            end else if (i_right && !i_left) begin
              cursor_d = (cursor_q == CUR_SEC) ? CUR_HOUR : cursor_q + 2'd1;
            end
          end else if (i_up ^ i_down) begin
            case (cursor_q)
              CUR_HOUR: begin
                if (i_up) hour_d = (hour_q == 5'd23) ? 5'd0  : hour_q + 5'd1;
                else      hour_d = (hour_q == 5'd0)  ? 5'd23 : hour_q - 5'd1;
              end
              CUR_MIN: begin
                if (i_up) min_d = (min_q == 6'd59) ? 6'd0  : min_q + 6'd1;
                else      min_d = (min_q == 6'd0)  ? 6'd59 : min_q - 6'd1;
              end
              CUR_SEC: begin
                if (i_up) sec_d = (sec_q == 6'd59) ? 6'd0  : sec_q + 6'd1;
                else      sec_d = (sec_q == 6'd0)  ? 6'd59 : sec_q - 6'd1;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        state_d  = RUN;
        cursor_d = CUR_HOUR;
      end
    endcase
  end

  // State registers; reset returns everything to 00:00:00 in RUN at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= RUN;
      hour_q   <= 5'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      cursor_q <= CUR_HOUR;
`ifdef CLKSET_AUTOEXIT_EN
      idle_q   <= 6'd0;
`endif
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      cursor_q <= cursor_d;
`ifdef CLKSET_AUTOEXIT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign o_hour   = hour_q;
  assign o_min    = min_q;
  assign o_sec    = sec_q;
  assign o_set    = (state_q == SET);
  assign o_cursor = cursor_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: the driver applies one directed vector
// per cycle and queues the hand-computed post-edge state; the monitor pops and
// compares after every rising edge. Auto-exit vectors run when
// CLKSET_AUTOEXIT_EN is defined for the build.
module tb_clock_set_ctrl;

  logic       clk, rstn;
  logic       up, down, left, right, mode, tick;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic       set;
  logic [1:0] cursor;

  clock_set_ctrl #(.TIMEOUT_SEC(10)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_up(up), .i_down(down), .i_left(left), .i_right(right),
    .i_mode(mode), .i_tick(tick),
    .o_hour(hour), .o_min(min), .o_sec(sec), .o_set(set), .o_cursor(cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    int       h, m, s, st, cur;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Button encoding: {up, down, left, right, mode, tick}
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] U = 6'b100000;
  localparam logic [5:0] D = 6'b010000;
  localparam logic [5:0] L = 6'b001000;
  localparam logic [5:0] R = 6'b000100;
  localparam logic [5:0] M = 6'b000010;
  localparam logic [5:0] T = 6'b000001;

  task automatic check(input string nm, input int h, input int m, input int s,
                       input int st, input int cur);
    n_chk++;
    if (int'(hour) != h || int'(min) != m || int'(sec) != s ||
        int'(set) != st || int'(cursor) != cur) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d set=%0d cur=%0d, want %0d:%0d:%0d set=%0d cur=%0d",
               nm, hour, min, sec, set, cursor, h, m, s, st, cur);
    end
  endtask

  // One vector per cycle: drive at negedge, expect the state after the next posedge.
  task automatic step(input string nm, input logic [5:0] b, input int h, input int m,
                      input int s, input int st, input int cur);
    exp_t e;
    @(negedge clk);
    {up, down, left, right, mode, tick} = b;
    e.name = nm; e.h = h; e.m = m; e.s = s; e.st = st; e.cur = cur;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    {up, down, left, right, mode, tick} = N;
  endtask

  // Monitor: outputs are registered, so every edge presents a new state.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, e.h, e.m, e.s, e.st, e.cur);
    end
  end

  initial begin
    {up, down, left, right, mode, tick} = N;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Reset state, then RUN counting
    step("reset",      N,       0, 0, 0, 0, 0);
    step("tick1",      T,       0, 0, 1, 0, 0);
    step("tick2",      T,       0, 0, 2, 0, 0);
    step("tick3",      T,       0, 0, 3, 0, 0);

    // Preload 23:59:59 through SET
    step("enter_set",  M,       0, 0, 3, 1, 0);
    step("hour_dn",    D,      23, 0, 3, 1, 0);
    step("cur_r1",     R,      23, 0, 3, 1, 1);
    step("min_dn",     D,      23,59, 3, 1, 1);
    step("cur_r2",     R,      23,59, 3, 1, 2);
    step("sec_dn2",    D,      23,59, 2, 1, 2);
    step("sec_dn1",    D,      23,59, 1, 1, 2);
    step("sec_dn0",    D,      23,59, 0, 1, 2);
    step("sec_wrap",   D,      23,59,59, 1, 2);
    step("cur_wrap_r", R,      23,59,59, 1, 0);
    step("cur_wrap_l", L,      23,59,59, 1, 2);
    step("cur_l",      L,      23,59,59, 1, 1);
    step("exit_set",   M,      23,59,59, 0, 0);
    step("midnight",   T,       0, 0, 0, 0, 0);

    // Hour wrap and cursor walk
    step("set2",       M,       0, 0, 0, 1, 0);
    step("hour_wrapd", D,      23, 0, 0, 1, 0);
    step("walk_r1",    R,      23, 0, 0, 1, 1);
    step("walk_r2",    R,      23, 0, 0, 1, 2);
    step("walk_r0",    R,      23, 0, 0, 1, 0);
    step("lr_nomove",  L|R,    23, 0, 0, 1, 0);
    step("lru_drop",   L|R|U,  23, 0, 0, 1, 0);
    step("hour_wrapu", U,       0, 0, 0, 1, 0);

    // Minute field, no carry; up+down cancels; arrow beats up
    step("to_min",     R,       0, 0, 0, 1, 1);
    step("min_wrapd",  D,       0,59, 0, 1, 1);
    step("min_wrapu",  U,       0, 0, 0, 1, 1);
    step("updn_none",  U|D,     0, 0, 0, 1, 1);
    step("r_beats_u",  R|U,     0, 0, 0, 1, 2);

    // Ticks frozen in SET; mode beats up
    for (int i = 0; i < 5; i++) step("set_frozen", T, 0, 0, 0, 1, 2);
    step("mode_beats", M|U,     0, 0, 0, 0, 0);

    // RUN ignores edit buttons; mode+tick applies tick and enters SET
    step("run_l_ign",  L,       0, 0, 0, 0, 0);
    step("run_u_ign",  U,       0, 0, 0, 0, 0);
    step("run_tick",   T,       0, 0, 1, 0, 0);
    step("mode_tick",  M|T,     0, 0, 2, 1, 0);

    // Load 00:59:59 and check minute->hour carry
    step("c_cur1",     R,       0, 0, 2, 1, 1);
    step("c_min59",    D,       0,59, 2, 1, 1);
    step("c_cur2",     R,       0,59, 2, 1, 2);
    step("c_sec1",     D,       0,59, 1, 1, 2);
    step("c_sec0",     D,       0,59, 0, 1, 2);
    step("c_sec59",    D,       0,59,59, 1, 2);
    step("c_run",      M,       0,59,59, 0, 0);
    step("hour_carry", T,       1, 0, 0, 0, 0);
    step("after_carry",T,       1, 0, 1, 0, 0);
    step("enter_set3", M,       1, 0, 1, 1, 0);
    step("to_min3",    R,       1, 0, 1, 1, 1);
    idle();

    // Asynchronous reset mid-operation: outputs clear without a clock edge
    #2 rstn = 1'b0;
    #1 check("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst",   N,       0, 0, 0, 0, 0);

`ifdef CLKSET_AUTOEXIT_EN
    step("ae_set",     M,       0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step("ae_tick9", T, 0, 0, 0, 1, 0);
    step("ae_btn_tick",U|T,     1, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step("ae_hold", T, 1, 0, 0, 1, 0);
    step("ae_exit",    T,       1, 0, 0, 0, 0);
    step("ae_run",     T,       1, 0, 1, 0, 0);
`endif

    idle();
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
